// File: rtl/reg_bus_pkg.sv
// Shared definitions for the register-bus arbiter: default bus widths,
// the data value returned on a timed-out access, and the FSM encoding.
package reg_bus_pkg;

    localparam int ASZ_DEF = 7;
    localparam int DSZ_DEF = 32;

    // Returned as read data when the target never acknowledges.
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner selection. Purely combinational; the caller
// registers the result and owns the last-grant history.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie the requester that was not served last wins; otherwise the
    // single pending requester wins. No request gives an all-zero grant.
    always_comb begin
        grant = 2'b00;
        if (valid == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Arbitrates two register-bus requesters (0 = SPI port, 1 = host bridge)
// onto a single target port, one transaction at a time.
//
// Handshake: a requester raises rq_valid[i] with stable rq_rnw/addr/wdata
// and holds them until it sees rq_ready[i] (a one-cycle pulse); a request
// withdrawn before that pulse is simply not served. Completion is reported
// later by a one-cycle rq_done[i] pulse, with rq_rdata/rq_err valid in that
// same cycle and held afterwards. On the target side exactly one of
// tgt_wr_en/tgt_rd_en pulses per transaction and the target answers with a
// one-cycle tgt_ack; an ack that does not arrive within TMO wait cycles is
// reported as an error with ERR_DATA as read data.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int ASZ = ASZ_DEF,
    parameter int DSZ = DSZ_DEF,
    parameter int TMO = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     rq_valid,
    input  logic [1:0]     rq_rnw,
    input  logic [ASZ-1:0] rq0_addr,
    input  logic [ASZ-1:0] rq1_addr,
    input  logic [DSZ-1:0] rq0_wdata,
    input  logic [DSZ-1:0] rq1_wdata,
    output logic [1:0]     rq_ready,
    output logic [1:0]     rq_done,
    output logic           rq_err,
    output logic [DSZ-1:0] rq_rdata,
    output logic [ASZ-1:0] tgt_addr,
    output logic [DSZ-1:0] tgt_wdata,
    output logic           tgt_wr_en,
    output logic           tgt_rd_en,
    input  logic [DSZ-1:0] tgt_rdata,
    input  logic           tgt_ack
);

    localparam logic [DSZ-1:0] ERR_Q   = DSZ'(ERR_DATA);
    localparam logic [7:0]     TMO_CNT = 8'(TMO);

    state_t         state;
    logic           winner;      // index of the requester being served
    logic           rnw_q;       // direction of the transaction in flight
    logic           last_grant;  // index served by the last completed transaction
    logic [7:0]     wait_cnt;    // WAIT cycles elapsed without an ack
    logic [7:0]     wait_cnt_nxt;

    logic [1:0]     grant;
    logic           g_idx;
    logic           win_rnw;
    logic [ASZ-1:0] win_addr;
    logic [DSZ-1:0] win_wdata;

    rr_arb2 u_arb (
        .valid (rq_valid),
        .last  (last_grant),
        .grant (grant)
    );

    assign g_idx        = grant[1];
    assign wait_cnt_nxt = wait_cnt + 8'd1;

    // Steer the winning requester's fields toward the target registers.
    always_comb begin
        win_rnw   = rq_rnw[g_idx];
        win_addr  = g_idx ? rq1_addr  : rq0_addr;
        win_wdata = g_idx ? rq1_wdata : rq0_wdata;
    end

    // Transaction FSM; every output is a register updated on state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            winner     <= 1'b0;
            rnw_q      <= 1'b0;
            last_grant <= 1'b1;
            wait_cnt   <= 8'd0;
            rq_ready   <= 2'b00;
            rq_done    <= 2'b00;
            rq_err     <= 1'b0;
            rq_rdata   <= '0;
            tgt_addr   <= '0;
            tgt_wdata  <= '0;
            tgt_wr_en  <= 1'b0;
            tgt_rd_en  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|rq_valid) begin
                        winner    <= g_idx;
                        rnw_q     <= win_rnw;
                        tgt_addr  <= win_addr;
                        tgt_wdata <= win_wdata;
                        rq_ready  <= grant;
                        tgt_wr_en <= ~win_rnw;
                        tgt_rd_en <= win_rnw;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Ready and strobe were raised on entry; drop them now.
                    rq_ready  <= 2'b00;
                    tgt_wr_en <= 1'b0;
                    tgt_rd_en <= 1'b0;
                    wait_cnt  <= 8'd0;
                    state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    // An ack on the same cycle as the timeout still counts as success.
                    if (tgt_ack) begin
                        rq_rdata <= rnw_q ? tgt_rdata : '0;
                        rq_err   <= 1'b0;
                        rq_done  <= {winner, ~winner};
                        state    <= ST_DONE;
                    end else if (wait_cnt_nxt == TMO_CNT) begin
                        rq_rdata <= ERR_Q;
                        rq_err   <= 1'b1;
                        rq_done  <= {winner, ~winner};
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt_nxt;
                    end
                end
                ST_DONE: begin
                    rq_done    <= 2'b00;
                    last_grant <= winner;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: single write, delayed read, two-way
// contention, timeout, ack/timeout collision and reset during WAIT.
module tb_reg_bus_arbiter;

    localparam int ASZ = 7;
    localparam int DSZ = 32;
    localparam int TMO = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     rq_valid;
    logic [1:0]     rq_rnw;
    logic [ASZ-1:0] rq0_addr;
    logic [ASZ-1:0] rq1_addr;
    logic [DSZ-1:0] rq0_wdata;
    logic [DSZ-1:0] rq1_wdata;
    logic [1:0]     rq_ready;
    logic [1:0]     rq_done;
    logic           rq_err;
    logic [DSZ-1:0] rq_rdata;
    logic [ASZ-1:0] tgt_addr;
    logic [DSZ-1:0] tgt_wdata;
    logic           tgt_wr_en;
    logic           tgt_rd_en;
    logic [DSZ-1:0] tgt_rdata;
    logic           tgt_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt = 0;
    logic [1:0] exp_q[$];

    reg_bus_arbiter #(
        .ASZ (ASZ),
        .DSZ (DSZ),
        .TMO (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rq_valid  (rq_valid),
        .rq_rnw    (rq_rnw),
        .rq0_addr  (rq0_addr),
        .rq1_addr  (rq1_addr),
        .rq0_wdata (rq0_wdata),
        .rq1_wdata (rq1_wdata),
        .rq_ready  (rq_ready),
        .rq_done   (rq_done),
        .rq_err    (rq_err),
        .rq_rdata  (rq_rdata),
        .tgt_addr  (tgt_addr),
        .tgt_wdata (tgt_wdata),
        .tgt_wr_en (tgt_wr_en),
        .tgt_rd_en (tgt_rd_en),
        .tgt_rdata (tgt_rdata),
        .tgt_ack   (tgt_ack)
    );

    // Clock
    always #5 clk = ~clk;

    // Count cycles carrying a target strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (tgt_wr_en || tgt_rd_en) strobe_cnt++;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"}, rq_ready, 2'b00);
        check({tag, "_done"},  rq_done, 2'b00);
        check({tag, "_err"},   rq_err, 1'b0);
        check({tag, "_rdata"}, rq_rdata, 32'h0);
        check({tag, "_addr"},  tgt_addr, 7'h0);
        check({tag, "_wdata"}, tgt_wdata, 32'h0);
        check({tag, "_strb"},  {tgt_wr_en, tgt_rd_en}, 2'b00);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rq_valid  = 2'b00;
        rq_rnw    = 2'b00;
        rq0_addr  = '0;
        rq1_addr  = '0;
        rq0_wdata = '0;
        rq1_wdata = '0;
        tgt_rdata = '0;
        tgt_ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // ---------------- reset state
        do_reset();
        check_zero("rst");

        // ---------------- single write from requester 0, ack on first WAIT cycle
        rq_valid = 2'b01; rq_rnw = 2'b00; rq0_addr = 7'h05; rq0_wdata = 32'h1234_5678;
        step();  // edge T
        check("wr_ready", rq_ready, 2'b01);
        check("wr_strb",  {tgt_wr_en, tgt_rd_en}, 2'b10);
        check("wr_addr",  tgt_addr, 7'h05);
        check("wr_wdata", tgt_wdata, 32'h1234_5678);
        rq_valid = 2'b00; rq0_addr = 7'h11; rq0_wdata = 32'h0;
        step();  // T+1, ISSUE -> WAIT
        check("wr_pulse_end", {rq_ready, tgt_wr_en, tgt_rd_en}, 4'b0000);
        tgt_ack = 1'b1;
        step();  // T+2, ack sampled
        tgt_ack = 1'b0;
        check("wr_done",      rq_done, 2'b01);
        check("wr_err",       rq_err, 1'b0);
        check("wr_addr_hold", tgt_addr, 7'h05);
        check("wr_data_hold", tgt_wdata, 32'h1234_5678);
        step();  // T+3
        check("wr_done_end",  rq_done, 2'b00);

        // ---------------- single read from requester 1, ack after 3 WAIT cycles
        rq_valid = 2'b10; rq_rnw = 2'b10; rq1_addr = 7'h7F;
        step();  // edge T
        check("rd_ready", rq_ready, 2'b10);
        check("rd_strb",  {tgt_wr_en, tgt_rd_en}, 2'b01);
        check("rd_addr",  tgt_addr, 7'h7F);
        rq_valid = 2'b00;
        tgt_ack = 1'b1; tgt_rdata = 32'h1111_1111;  // lands in ISSUE: ignored
        step();  // T+1
        tgt_ack = 1'b0; tgt_rdata = 32'h0;
        check("rd_issue_ack_ignored", rq_done, 2'b00);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rd_no_done_yet", rq_done, 2'b00);
        end
        tgt_ack = 1'b1; tgt_rdata = 32'hA5A5_A5A5;
        step();
        tgt_ack = 1'b0; tgt_rdata = 32'h0;
        check("rd_done",  rq_done, 2'b10);
        check("rd_rdata", rq_rdata, 32'hA5A5_A5A5);
        check("rd_err",   rq_err, 1'b0);
        step();
        check("rd_done_end",   rq_done, 2'b00);
        check("rd_rdata_hold", rq_rdata, 32'hA5A5_A5A5);

        // ---------------- contention: both valid continuously after reset
        do_reset();
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        exp_q.push_back(2'b01); exp_q.push_back(2'b10);
        begin
            int s0;
            s0 = strobe_cnt;
            rq_rnw = 2'b10; rq0_addr = 7'h10; rq1_addr = 7'h20;
            rq0_wdata = 32'h0000_0A0A; rq1_wdata = 32'h0000_0B0B;
            rq_valid = 2'b11;
            for (int k = 0; k < 4; k++) begin
                int wait_n;
                logic [1:0] exp;
                wait_n = 0;
                step();
                while (rq_ready == 2'b00 && wait_n < 8) begin
                    step();
                    wait_n++;
                end
                check("cont_ready_seen", rq_ready != 2'b00, 1'b1);
                exp = exp_q.pop_front();
                check("cont_grant", rq_ready, exp);
                check("cont_one_strobe", {1'b0, tgt_wr_en} + {1'b0, tgt_rd_en}, 2'd1);
                check("cont_dir", tgt_rd_en, exp[1]);
                check("cont_addr", tgt_addr, exp[1] ? 7'h20 : 7'h10);
                step();  // into WAIT
                tgt_ack = 1'b1; tgt_rdata = 32'h0000_00C0 + 32'(k);
                step();
                tgt_ack = 1'b0;
                check("cont_done", rq_done, exp);
                check("cont_rdata", rq_rdata, exp[1] ? 32'h0000_00C0 + 32'(k) : 32'h0);
            end
            rq_valid = 2'b00;
            check("cont_strobes", strobe_cnt - s0, 4);
        end
        step();  // DONE -> IDLE

        // ---------------- timeout: read with no ack
        rq_valid = 2'b01; rq_rnw = 2'b01; rq0_addr = 7'h33;
        step();
        check("tmo_ready", rq_ready, 2'b01);
        rq_valid = 2'b00;
        step();  // into WAIT
        for (int i = 0; i < TMO - 1; i++) begin
            step();
            check("tmo_no_done_yet", rq_done, 2'b00);
        end
        step();  // TMO-th WAIT cycle
        check("tmo_done",  rq_done, 2'b01);
        check("tmo_err",   rq_err, 1'b1);
        check("tmo_rdata", rq_rdata, 32'hDEAD_BEEF);
        step();  // back to IDLE
        check("tmo_done_end", rq_done, 2'b00);
        tgt_ack = 1'b1; tgt_rdata = 32'h1212_1212;  // late ack in IDLE
        step();
        tgt_ack = 1'b0;
        check("late_ack_done",  rq_done, 2'b00);
        check("late_ack_strb",  {rq_ready, tgt_wr_en, tgt_rd_en}, 4'b0000);
        check("late_ack_rdata", rq_rdata, 32'hDEAD_BEEF);
        check("late_ack_err",   rq_err, 1'b1);
        step();
        check("late_ack_done2", rq_done, 2'b00);

        // ---------------- ack on the same cycle the timeout would fire
        rq_valid = 2'b01; rq_rnw = 2'b01; rq0_addr = 7'h44;
        step();
        check("col_ready", rq_ready, 2'b01);
        rq_valid = 2'b00;
        step();
        for (int i = 0; i < TMO - 1; i++) begin
            step();
            check("col_no_done_yet", rq_done, 2'b00);
        end
        tgt_ack = 1'b1; tgt_rdata = 32'h0BAD_F00D;
        step();
        tgt_ack = 1'b0; tgt_rdata = 32'h0;
        check("col_done",  rq_done, 2'b01);
        check("col_err",   rq_err, 1'b0);
        check("col_rdata", rq_rdata, 32'h0BAD_F00D);
        step();  // last_grant is now 0

        // ---------------- reset asserted during WAIT
        rq_valid = 2'b10; rq_rnw = 2'b00; rq1_addr = 7'h55; rq1_wdata = 32'hCAFE_F00D;
        step();
        check("rw_ready", rq_ready, 2'b10);
        rq_valid = 2'b00;
        step();  // WAIT
        step();  // still WAIT
        rst = 1'b1;
        #1;
        check_zero("rw_async");
        for (int i = 0; i < 3; i++) begin
            step();
            check("rw_no_done", rq_done, 2'b00);
        end
        check_zero("rw_held");
        rq_valid = 2'b11; rq_rnw = 2'b00; rq0_addr = 7'h66; rq0_wdata = 32'h0000_0066;
        rst = 1'b0;
        step();  // first edge after release accepts, requester 0 wins the tie
        check("rw_tie_grant", rq_ready, 2'b01);
        check("rw_tie_addr",  tgt_addr, 7'h66);
        rq_valid = 2'b00;
        step();
        tgt_ack = 1'b1;
        step();
        tgt_ack = 1'b0;
        check("rw_tie_done", rq_done, 2'b01);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
